// File: rtl/armleocpu_mem_pkg.sv
// armleocpu_mem_pkg: state encodings shared by single-port memory controllers
package armleocpu_mem_pkg;
   typedef logic [1:0] state_t;
   localparam state_t STATE_CLEAR = 2'd0;
   localparam state_t STATE_IDLE  = 2'd1;
   localparam state_t STATE_RESP  = 2'd2;
endpackage

// File: rtl/armleocpu_mem_1rw.sv
// armleocpu_mem_1rw: single-port RAM with registered read data that holds while read is low
module armleocpu_mem_1rw #(
   parameter int ELEMENTS_W = 7,
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic [ELEMENTS_W-1:0] address,
   input  logic                  read,
   output logic [WIDTH-1:0]      readdata,
   input  logic                  write,
   input  logic [WIDTH-1:0]      writedata
);
   logic [WIDTH-1:0] storage [2**ELEMENTS_W];
   always_ff @(posedge clk) begin
      if (write) storage[address] <= writedata;
      if (read) readdata <= storage[address];
   end
endmodule

// File: rtl/armleocpu_mem_1rw_ctrl.sv
// armleocpu_mem_1rw_ctrl: valid/ready request/response front end for armleocpu_mem_1rw with optional zero-fill
module armleocpu_mem_1rw_ctrl
   import armleocpu_mem_pkg::*;
#(
   parameter int ELEMENTS_W = 7,
   parameter int WIDTH = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ELEMENTS_W-1:0] req_address,
   input  logic [WIDTH-1:0]      req_writedata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WIDTH-1:0]      resp_readdata,
   output logic                  busy
);
   state_t                state;
   logic [ELEMENTS_W-1:0] counter;
   logic                  clearing, mem_read, mem_write;
   logic [ELEMENTS_W-1:0] mem_address;
   logic [WIDTH-1:0]      mem_writedata;
   // In RESP a new request is only taken when the current response leaves, so readdata never changes under stall
   always_comb begin
      clearing = state == STATE_CLEAR;
      req_ready = state == STATE_IDLE || (state == STATE_RESP && resp_ready);
      mem_read = req_valid && req_ready && !req_write;
      mem_write = clearing || (req_valid && req_ready && req_write);
      mem_address = clearing ? counter : req_address;
      mem_writedata = clearing ? '0 : req_writedata;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR_ON_RESET ? STATE_CLEAR : STATE_IDLE;
         busy <= CLEAR_ON_RESET;
         counter <= '0;
         resp_valid <= 1'b0;
      end else if (clearing) begin
         counter <= &counter ? counter : counter + 1'b1;
         state <= &counter ? STATE_IDLE : STATE_CLEAR;
         busy <= !(&counter);
      end else if (req_ready) begin
         state <= mem_read ? STATE_RESP : STATE_IDLE;
         resp_valid <= mem_read;
      end
   end
   armleocpu_mem_1rw #(
      .ELEMENTS_W(ELEMENTS_W),
      .WIDTH(WIDTH)
   ) u_mem (
      .clk(clk),
      .address(mem_address),
      .read(mem_read),
      .readdata(resp_readdata),
      .write(mem_write),
      .writedata(mem_writedata)
   );
endmodule

// File: tb/tb_armleocpu_mem_1rw_ctrl.sv
// tb_armleocpu_mem_1rw_ctrl: randomized scoreboard bench for the single-port memory controller
module tb_armleocpu_mem_1rw_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [6:0]  req_address = '0;
   logic [31:0] req_writedata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_readdata;
   logic        busy;
   int          compared = 0;
   int          mismatched = 0;
   int          handshakes = 0;
   logic [31:0] model_mem [128];
   logic [31:0] exp_q [$];
   bit          stalled = 1'b0;
   logic [31:0] held = '0;

   armleocpu_mem_1rw_ctrl #(
      .ELEMENTS_W(7),
      .WIDTH(32),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_address(req_address),
      .req_writedata(req_writedata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_readdata(resp_readdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a reset re-zeroes the array (clear pass) and drops pending reads
   initial forever begin
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         foreach (model_mem[i]) model_mem[i] = '0;
      end else if (req_valid && req_ready) begin
         if (req_write) model_mem[req_address] = req_writedata;
         else exp_q.push_back(model_mem[req_address]);
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else begin
         if (stalled) check("bp_stable", resp_readdata, held);
         if (resp_valid && !resp_ready) check("bp_req_ready", 32'(req_ready), 32'd0);
         if (resp_valid && resp_ready) begin
            handshakes++;
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL resp_unexpected: got response %h, expected none", resp_readdata);
            end else check("resp_data", resp_readdata, exp_q.pop_front());
         end
         stalled = resp_valid && !resp_ready;
         held = resp_readdata;
      end
   end

   task automatic issue(input logic wr, input logic [6:0] a, input logic [31:0] d, input bit rand_bp);
      bit ok;
      int n = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_address = a;
      req_writedata = d;
      do begin
         if (rand_bp) resp_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         ok = req_ready;
         step();
         n++;
      end while (!ok && n < 200);
      if (!ok) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: got no req_ready in %0d cycles, expected acceptance", n);
      end
      req_valid = 1'b0;
   endtask

   task automatic clear_check();
      int n = 0;
      int bad = 0;
      while (busy && n < 300) begin
         if (req_ready || resp_valid) bad++;
         step();
         n++;
      end
      check("clear_cycles", n, 128);
      check("clear_quiet", bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      clear_check();
      resp_ready = 1'b1;
      issue(1'b0, 7'd0, '0, 1'b0);
      check("clear_rd0", resp_readdata, 32'h0);
      issue(1'b0, 7'd64, '0, 1'b0);
      check("clear_rd64", resp_readdata, 32'h0);
      issue(1'b0, 7'd127, '0, 1'b0);
      check("clear_rd127", resp_readdata, 32'h0);
      step();
      issue(1'b1, 7'd5, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 7'd5, '0, 1'b0);
      check("wr_rd_valid", 32'(resp_valid), 32'd1);
      check("wr_rd_data", resp_readdata, 32'hDEADBEEF);
      step();
      resp_ready = 1'b0;
      begin
         int hs0;
         hs0 = handshakes;
         issue(1'b0, 7'd5, '0, 1'b0);
         for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            check("bp_data", resp_readdata, 32'hDEADBEEF);
            step();
         end
         resp_ready = 1'b1;
         step();
         step();
         check("bp_handshakes", handshakes - hs0, 1);
         check("bp_drained", 32'(resp_valid), 32'd0);
      end
      issue(1'b1, 7'd1, 32'h11, 1'b0);
      issue(1'b1, 7'd2, 32'h22, 1'b0);
      issue(1'b1, 7'd3, 32'h33, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         issue(1'b0, 7'(i), '0, 1'b0);
         check("stream_valid", 32'(resp_valid), 32'd1);
      end
      step();
      issue(1'b1, 7'd127, 32'hFFFFFFFF, 1'b0);
      issue(1'b0, 7'd127, '0, 1'b0);
      check("bound_127", resp_readdata, 32'hFFFFFFFF);
      issue(1'b0, 7'd0, '0, 1'b0);
      check("bound_0", resp_readdata, 32'h0);
      step();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            resp_ready = $urandom_range(0, 3) != 0;
            step();
         end else issue(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom, 1'b1);
      end
      resp_ready = 1'b1;
      step();
      step();
      check("rand_drained", exp_q.size(), 0);
      resp_ready = 1'b0;
      issue(1'b0, 7'd9, '0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) step();
      rst = 1'b1;
      step();
      check("midclr_resp_valid", 32'(resp_valid), 32'd0);
      check("midclr_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      resp_ready = 1'b1;
      clear_check();
      issue(1'b0, 7'd5, '0, 1'b0);
      check("reclear_5", resp_readdata, 32'h0);
      issue(1'b0, 7'd127, '0, 1'b0);
      check("reclear_127", resp_readdata, 32'h0);
      step();
      step();
      check("final_queue", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
